// File: rtl/gradient_valve_sequencer_if.sv
// Host-side config/handshake and valve-driver bundle for the gradient valve sequencer.
// The master drives config and strobes; the slave (sequencer) drives the valve pins and status.
interface gradient_valve_sequencer_if #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 7,
   parameter int CNT_W = 16,
   parameter int PWM_W = 8
);
   localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic                    start;
   logic                    stop;
   logic                    pingpong;
   logic [N_IN*PWM_W-1:0]   duty;
   logic [CNT_W-1:0]        prime_cyc;
   logic [CNT_W-1:0]        dwell_cyc;
   logic [CNT_W-1:0]        settle_cyc;
   logic [N_IN-1:0]         in_valve;
   logic [N_OUT-1:0]        out_valve;
   logic [IDX_W-1:0]        cur_outlet;
   logic                    busy;
   logic                    done;

   modport master (
      output start, stop, pingpong, duty, prime_cyc, dwell_cyc, settle_cyc,
      input  in_valve, out_valve, cur_outlet, busy, done
   );

   modport slave (
      input  start, stop, pingpong, duty, prime_cyc, dwell_cyc, settle_cyc,
      output in_valve, out_valve, cur_outlet, busy, done
   );
endinterface

// File: rtl/gradient_valve_sequencer.sv
// Valve sequencer: inlet PWM plus a one-hot outlet sweep (single or ping-pong) with
// break-before-make settle gaps. Outputs are registered from the next-state values.
module gradient_valve_sequencer #(
   parameter int N_IN  = 2,
   parameter int N_OUT = 7,
   parameter int CNT_W = 16,
   parameter int PWM_W = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   gradient_valve_sequencer_if.slave   bus
);
   localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT - 1);

   typedef enum logic [2:0] {IDLE, PRIME, DWELL, SETTLE, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    dir_down_reg, dir_down_next;
   logic [PWM_W-1:0]        pwm_reg, pwm_next;
   logic [N_IN*PWM_W-1:0]   duty_sh_reg, duty_sh_next;
   logic [CNT_W-1:0]        dwell_sh_reg, dwell_sh_next;
   logic [CNT_W-1:0]        settle_sh_reg, settle_sh_next;
   logic                    pingpong_sh_reg, pingpong_sh_next;

   logic [N_IN-1:0]         in_valve_reg, in_valve_next;
   logic [N_OUT-1:0]        out_valve_reg, out_valve_next;
   logic [IDX_W-1:0]        cur_outlet_reg;
   logic                    busy_reg, busy_next;
   logic                    done_reg, done_next;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         idx_reg         <= '0;
         dir_down_reg    <= 1'b0;
         pwm_reg         <= '0;
         duty_sh_reg     <= '0;
         dwell_sh_reg    <= '0;
         settle_sh_reg   <= '0;
         pingpong_sh_reg <= 1'b0;
         in_valve_reg    <= '0;
         out_valve_reg   <= '0;
         cur_outlet_reg  <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         state_reg       <= state_next;
         cnt_reg         <= cnt_next;
         idx_reg         <= idx_next;
         dir_down_reg    <= dir_down_next;
         pwm_reg         <= pwm_next;
         duty_sh_reg     <= duty_sh_next;
         dwell_sh_reg    <= dwell_sh_next;
         settle_sh_reg   <= settle_sh_next;
         pingpong_sh_reg <= pingpong_sh_next;
         in_valve_reg    <= in_valve_next;
         out_valve_reg   <= out_valve_next;
         cur_outlet_reg  <= idx_next;
         busy_reg        <= busy_next;
         done_reg        <= done_next;
      end
   end

   always_comb begin
      state_next       = state_reg;
      cnt_next         = cnt_reg;
      idx_next         = idx_reg;
      dir_down_next    = dir_down_reg;
      pwm_next         = pwm_reg + PWM_W'(1);
      duty_sh_next     = duty_sh_reg;
      dwell_sh_next    = dwell_sh_reg;
      settle_sh_next   = settle_sh_reg;
      pingpong_sh_next = pingpong_sh_reg;

      if (bus.stop) begin
         state_next    = IDLE;
         idx_next      = '0;
         dir_down_next = 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               if (bus.start) begin
                  state_next       = PRIME;
                  cnt_next         = bus.prime_cyc;
                  idx_next         = '0;
                  dir_down_next    = 1'b0;
                  pwm_next         = '0;
                  duty_sh_next     = bus.duty;
                  dwell_sh_next    = bus.dwell_cyc;
                  settle_sh_next   = bus.settle_cyc;
                  pingpong_sh_next = bus.pingpong;
               end
            end
            PRIME: begin
               if (cnt_reg == '0) begin
                  state_next = DWELL;
                  idx_next   = '0;
                  cnt_next   = dwell_sh_reg;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            DWELL: begin
               if (cnt_reg == '0) begin
                  state_next = SETTLE;
                  cnt_next   = settle_sh_reg;
               end else begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end
            end
            SETTLE: begin
               if (cnt_reg != '0) begin
                  cnt_next = cnt_reg - CNT_W'(1);
               end else if (!pingpong_sh_reg && idx_reg == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  state_next = DWELL;
                  cnt_next   = dwell_sh_reg;
                  // Turning at an end visits that end outlet only once per turn.
                  if (!pingpong_sh_reg) begin
                     idx_next = idx_reg + IDX_W'(1);
                  end else if (!dir_down_reg) begin
                     if (idx_reg == LAST_IDX) begin
                        dir_down_next = 1'b1;
                        idx_next      = idx_reg - IDX_W'(1);
                     end else begin
                        idx_next = idx_reg + IDX_W'(1);
                     end
                  end else begin
                     if (idx_reg == '0) begin
                        dir_down_next = 1'b0;
                        idx_next      = idx_reg + IDX_W'(1);
                     end else begin
                        idx_next = idx_reg - IDX_W'(1);
                     end
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy_next = (state_next == PRIME) || (state_next == DWELL) || (state_next == SETTLE);
   assign done_next = (state_next == DONE) && (state_reg != DONE);

   genvar gi;
   generate
      for (gi = 0; gi < N_OUT; gi++) begin : g_out
         assign out_valve_next[gi] = (state_next == DWELL) && (idx_next == IDX_W'(gi));
      end
      for (gi = 0; gi < N_IN; gi++) begin : g_in
         assign in_valve_next[gi] = busy_next && (pwm_next < duty_sh_next[gi*PWM_W +: PWM_W]);
      end
   endgenerate

   assign bus.in_valve   = in_valve_reg;
   assign bus.out_valve  = out_valve_reg;
   assign bus.cur_outlet = cur_outlet_reg;
   assign bus.busy       = busy_reg;
   assign bus.done       = done_reg;
endmodule
